// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } sw_state_e;

    localparam int NDIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] pick_nib(
        input logic [23:0] d,
        input logic [2:0]  i
    );
        logic [3:0] n;
        n = 4'h0;
        case (i)
            3'd0:    n = d[23:20];
            3'd1:    n = d[19:16];
            3'd2:    n = d[15:12];
            3'd3:    n = d[11:8];
            3'd4:    n = d[7:4];
            3'd5:    n = d[3:0];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment code.
// Values above 9 show a dash; blank overrides everything.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        if (blank) begin
            seg_n = SEG_BLANK;
        end else begin
            case (nib)
                4'd0:    seg_n = SEG_0;
                4'd1:    seg_n = SEG_1;
                4'd2:    seg_n = SEG_2;
                4'd3:    seg_n = SEG_3;
                4'd4:    seg_n = SEG_4;
                4'd5:    seg_n = SEG_5;
                4'd6:    seg_n = SEG_6;
                4'd7:    seg_n = SEG_7;
                4'd8:    seg_n = SEG_8;
                4'd9:    seg_n = SEG_9;
                default: seg_n = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// Six-digit multiplexed stopwatch display with lap freeze.
// Slot 0 is min10 (an_n[5]); slot 5 is cs1 (an_n[0]).
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        read,
    input  logic        time_upd,
    input  logic [23:0] time_bcd,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [5:0]  an_n,
    output logic        frozen
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);
    localparam logic [2:0]    IDX_MAX = 3'(NDIGITS - 1);

    sw_state_e   state_q;
    sw_state_e   state_d;
    logic        disp_ld;
    logic [23:0] disp;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [3:0] nib;
    logic       lz_blank;
    logic [6:0] seg_dec;
    logic [5:0] an_sel;
    logic       active;

    // Freeze FSM: read toggles; disp reloads on every read edge.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        disp_ld = 1'b0;
        case (state_q)
            LIVE: begin
                if (read) begin
                    state_d = FROZEN;
                    disp_ld = 1'b1;
                end else if (time_upd) begin
                    disp_ld = 1'b1;
                end
            end
            FROZEN: begin
                if (read) begin
                    state_d = LIVE;
                    disp_ld = 1'b1;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            disp <= 24'h0;
        end else if (disp_ld) begin
            disp <= time_bcd;
        end
    end

    assign frozen = (state_q == FROZEN);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign nib      = pick_nib(disp, idx);
    assign lz_blank = (idx == 3'd0) && (nib == 4'd0);
    assign active   = (cnt >= CNT_BLK);
    assign an_sel   = ~(6'b100000 >> idx);

    seg7_decode u_dec (
        .nib   (nib),
        .blank (lz_blank),
        .seg_n (seg_dec)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            an_n  <= 6'h3F;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (!active) begin
            an_n  <= 6'h3F;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_sel;
            seg_n <= seg_dec;
            dp_n  <= ~((idx == 3'd1) || (idx == 3'd3));
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display (DIV=10, one blank cycle).
// Expected segment patterns are written out by hand.
module tb_stopwatch_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic        read = 1'b0;
    logic        time_upd = 1'b0;
    logic [23:0] time_bcd = 24'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [5:0]  an_n;
    logic        frozen;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_display #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (1)
    ) dut (
        .clk      (clk),
        .rest     (rest),
        .read     (read),
        .time_upd (time_upd),
        .time_bcd (time_bcd),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .frozen   (frozen)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_upd(input logic [23:0] v);
        time_bcd = v;
        time_upd = 1'b1;
        tick();
        time_upd = 1'b0;
    endtask

    task automatic pulse_read(input logic [23:0] v);
        time_bcd = v;
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    // Align to the first active cycle of slot 0.
    task automatic sync_slot0();
        int n;
        n = 0;
        while (an_n == 6'h1F && n < 100) begin
            tick();
            n++;
        end
        while (an_n != 6'h1F && n < 100) begin
            tick();
            n++;
        end
        chk("sync_timeout", 32'(n >= 100), 32'd0);
    endtask

    task automatic scan_check(input string tag, input logic [41:0] exp);
        logic [5:0] ea;
        sync_slot0();
        for (int i = 0; i < 6; i++) begin
            ea = ~(6'b100000 >> i);
            chk({tag, "_an"}, 32'(an_n), 32'(ea));
            chk({tag, "_seg"}, 32'(seg_n), 32'(exp[41-7*i -: 7]));
            chk({tag, "_dp"}, 32'(dp_n), (i == 1 || i == 3) ? 32'd0 : 32'd1);
            repeat (8) tick();
            chk({tag, "_an_end"}, 32'(an_n), 32'(ea));
            tick();
            chk({tag, "_blk_an"}, 32'(an_n), 32'h3F);
            chk({tag, "_blk_seg"}, 32'(seg_n), 32'h7F);
            chk({tag, "_blk_dp"}, 32'(dp_n), 32'd1);
            tick();
        end
    endtask

    initial begin
        // Reset held for 5 cycles
        repeat (5) tick();
        chk("rst_an", 32'(an_n), 32'h3F);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_frz", 32'(frozen), 32'd0);
        @(negedge clk);
        rest = 1'b1;
        tick();
        chk("rel_e1_an", 32'(an_n), 32'h3F);
        tick();
        chk("rel_e2_an", 32'(an_n), 32'h1F);

        // Live update
        pulse_upd(24'h012345);
        scan_check("live", {SB, S1, S2, S3, S4, S5});

        // Mid-slot change shows up one cycle later, scan unaffected
        sync_slot0();
        repeat (12) tick();
        pulse_upd(24'h070000);
        chk("mid_old_seg", 32'(seg_n), 32'(S1));
        tick();
        chk("mid_new_seg", 32'(seg_n), 32'(S7));
        chk("mid_an", 32'(an_n), 32'h2F);

        // Freeze, ignore update, then release
        pulse_read(24'h105999);
        chk("frz_on", 32'(frozen), 32'd1);
        pulse_upd(24'h110000);
        chk("frz_hold", 32'(frozen), 32'd1);
        scan_check("frz", {S1, S0, S5, S9, S9, S9});
        pulse_read(24'h110000);
        chk("frz_off", 32'(frozen), 32'd0);
        scan_check("unfrz", {S1, S1, S0, S0, S0, S0});

        // read and time_upd together in LIVE
        time_upd = 1'b1;
        pulse_read(24'h000042);
        time_upd = 1'b0;
        chk("sim_frz", 32'(frozen), 32'd1);
        scan_check("sim", {SB, S0, S0, S0, S4, S2});
        pulse_read(24'h0A0000);
        chk("sim_unfrz", 32'(frozen), 32'd0);

        // Invalid digit in min1
        scan_check("inv", {SB, SD, S0, S0, S0, S0});

        // Reset while frozen discards the lap
        pulse_read(24'h123456);
        chk("rf_frz", 32'(frozen), 32'd1);
        repeat (3) tick();
        rest = 1'b0;
        #1;
        chk("rf_async_frz", 32'(frozen), 32'd0);
        chk("rf_async_an", 32'(an_n), 32'h3F);
        chk("rf_async_seg", 32'(seg_n), 32'h7F);
        chk("rf_async_dp", 32'(dp_n), 32'd1);
        tick();
        @(negedge clk);
        rest = 1'b1;
        tick();
        chk("rf_e1_an", 32'(an_n), 32'h3F);
        tick();
        chk("rf_e2_an", 32'(an_n), 32'h1F);
        chk("rf_e2_seg", 32'(seg_n), 32'h7F);
        scan_check("rf", {SB, S0, S0, S0, S0, S0});
        chk("rf_end_frz", 32'(frozen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter SCAN_HZ, default 1000, meaning the digit-slot rate in Hz; DIV = CLK_HZ/SCAN_HZ cycles per slot, and DIV SHALL be at least 4.
REQ-003 The module SHALL have parameter BLANK_CYC, default 2, meaning the blank cycles at the start of each slot; BLANK_CYC SHALL be less than DIV.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The module SHALL have port rest, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port read, input, 1 bit: single-cycle debounced pulse that toggles lap-freeze.
REQ-007 The module SHALL have port time_upd, input, 1 bit: single-cycle strobe meaning time_bcd carries a new value.
REQ-008 The module SHALL have port time_bcd, input, 24 bits: six BCD digits {min10, min1, sec10, sec1, cs10, cs1}, with min10 in [23:20].
REQ-009 The module SHALL have port seg_n, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The module SHALL have port dp_n, output, 1 bit: decimal point, active-low.
REQ-011 The module SHALL have port an_n, output, 6 bits: digit enables, active-low; an_n[5] drives min10 and an_n[0] drives cs1.
REQ-012 The module SHALL have port frozen, output, 1 bit: high while the display holds a lap value.

Function
REQ-013 The block SHALL hold a 24-bit display register disp and a two-state machine with states LIVE and FROZEN.
REQ-014 In LIVE, on a cycle with time_upd=1, disp SHALL load time_bcd at that clock edge.
REQ-015 In LIVE, on a cycle with read=1, the state SHALL go to FROZEN and disp SHALL load the time_bcd present in that same cycle, whether or not time_upd is high.
REQ-016 In FROZEN, time_upd SHALL be ignored and disp SHALL hold its value.
REQ-017 In FROZEN, on a cycle with read=1, the state SHALL go to LIVE and disp SHALL load time_bcd at that same edge.
REQ-018 frozen SHALL be 1 exactly when the state is FROZEN, registered with no extra latency.
REQ-019 The scan logic SHALL use a divider counter running 0..DIV-1 that wraps to 0, and a slot index running 0..5 that advances when the divider wraps, with index 5 wrapping to 0.
REQ-020 Slot index i SHALL select digit nibble disp[23-4i -: 4] and the enable line an_n[5-i].
REQ-021 While the divider is below BLANK_CYC, all an_n bits SHALL be 1 and seg_n SHALL be 7'h7F.
REQ-022 While the divider is at or above BLANK_CYC, exactly one an_n bit SHALL be 0.
REQ-023 seg_n, dp_n and an_n SHALL be registered outputs, one cycle behind the divider and index values that produce them.
REQ-024 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 A nibble value above 9 SHALL display '-' (0111111).
REQ-026 Leading-zero suppression: when min10 equals 0, its slot SHALL show blank (1111111) while its an_n bit is still driven low.
REQ-027 dp_n SHALL be 0 during active cycles of slots 1 and 3 (after min1 and after sec1) and 1 at all other times.
REQ-028 A change of disp mid-slot SHALL appear on seg_n on the next cycle, without restarting the scan.

Reset
REQ-029 While rest=0, the block SHALL asynchronously force: state LIVE, frozen=0, disp=0, divider=0, index=0, an_n=6'h3F, seg_n=7'h7F, dp_n=1.
REQ-030 Reset SHALL take priority over read and time_upd in any cycle.
REQ-031 Reset SHALL deassert synchronously internally, and the first active slot after deassertion SHALL be index 0.
REQ-032 A reset asserted while FROZEN SHALL discard the lap value.

Structure
REQ-033 Package stopwatch_pkg SHALL hold the state enum (LIVE, FROZEN), the segment-code constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK, and the digit count 6.
REQ-034 The design SHALL use one combinational sub-module, seg7_decode, that maps a nibble and a blank flag to seg_n, instantiated once on the selected digit.
REQ-035 The scan divider, slot index, freeze FSM and output registers SHALL live in stopwatch_display.

Verification
REQ-036 The bench SHALL use CLK_HZ=1000, SCAN_HZ=100 (DIV=10) and BLANK_CYC=1.
REQ-037 Scenario reset: hold rest=0 for 5 cycles -> an_n=3F, seg_n=7F, dp_n=1, frozen=0; after release the first low enable is an_n=1F, two cycles after the edge.
REQ-038 Scenario live: time_upd with time_bcd=24'h012345 -> slots show blank, 1, 2, 3, 4, 5; dp_n=0 in slots 1 and 3 only; each slot is 9 active cycles plus 1 blank cycle.
REQ-039 Scenario freeze: read while time_bcd=24'h105999, then time_upd with 24'h110000 -> frozen=1 and the display stays 1,0,5,9,9,9; a second read -> frozen=0 and the display shows 1,1,0,0,0,0.
REQ-040 Scenario simultaneous: in LIVE, read and time_upd in the same cycle with 24'h000042 -> frozen=1 and disp=000042.
REQ-041 Scenario invalid digit: time_bcd=24'h0A0000 -> slot 1 shows seg_n=0111111.
REQ-042 Scenario reset while frozen: frozen=1, then pulse rest=0 -> frozen=0, disp=0, and the scan restarts at index 0.
